crossbar_out_arbiter: RTL

- Output-port scheduler for the crossbar.
- One instance sits per output port. It collects the per-destination trans_req bits from all P_CROSSBAR_N crossbar lines and grants exactly one at a time, round-robin, at packet granularity.
- It muxes the granted line's AXI-Stream onto the single physical output port and steers tready back to the granted line only.
- Grant is held until the packet's tlast beat is accepted downstream.

---
 rtl/crossbar_pkg.sv | 25 ++
 rtl/crossbar_rr_pick.sv | 33 +++
 rtl/crossbar_out_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar output-port scheduler: default sizes,
// arbiter state encoding and a one-hot to index helper.
package crossbar_pkg;

  localparam int P_CROSSBAR_N = 4;
  localparam int P_DATA_WIDTH = 64;
  localparam int P_KEEP_WIDTH = P_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index of the set bit of a one-hot vector (zero-extended to 32 bits).
  // An all-zero vector maps to index 0.
  function automatic int unsigned onehot_to_idx(input logic [31:0] i_oh);
    int unsigned v_idx;
    v_idx = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      v_idx = v_idx | (i_oh[i] ? i : 32'd0);
    end
    return v_idx;
  endfunction

endpackage

// File: rtl/crossbar_rr_pick.sv
// Combinational round-robin selector: the first requester at or after the
// pointer, wrapping modulo the line count, wins.
module crossbar_rr_pick #(
  parameter int P_CROSSBAR_N = 4,
  parameter int P_IDX_W      = 2
) (
  input  logic [P_CROSSBAR_N-1:0] i_req,
  input  logic [P_IDX_W-1:0]      i_ptr,
  output logic [P_CROSSBAR_N-1:0] o_winner,
  output logic                    o_valid
);
  import crossbar_pkg::*;

  assign o_valid = |i_req;

  // Walk the lines starting at the pointer and keep the first requester.
  always_comb begin
    logic [P_IDX_W-1:0] v_pos;
    logic               v_found;
    o_winner = '0;
    v_found  = 1'b0;
    for (int i = 0; i < P_CROSSBAR_N; i++) begin
      v_pos = P_IDX_W'((int'(i_ptr) + i) % P_CROSSBAR_N);
      if (!v_found && i_req[v_pos]) begin
        o_winner[v_pos] = 1'b1;
        v_found         = 1'b1;
      end else begin
        v_found = v_found;
      end
    end
  end

endmodule

// File: rtl/crossbar_out_arbiter.sv
// Per-output-port scheduler: grants one crossbar line at a time with
// packet-granular round-robin, muxes its AXI-Stream onto the output and
// steers tready back to the granted line only.
module crossbar_out_arbiter #(
  parameter int P_CROSSBAR_N = crossbar_pkg::P_CROSSBAR_N,
  parameter int P_DATA_WIDTH = crossbar_pkg::P_DATA_WIDTH
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [P_CROSSBAR_N-1:0]                 i_trans_req,
  output logic [P_CROSSBAR_N-1:0]                 o_trans_grant,
  input  logic [P_CROSSBAR_N-1:0]                 s_axis_tvalid,
  input  logic [P_CROSSBAR_N*P_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [P_CROSSBAR_N-1:0]                 s_axis_tlast,
  input  logic [P_CROSSBAR_N*P_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [P_CROSSBAR_N-1:0]                 s_axis_tuser,
  output logic [P_CROSSBAR_N-1:0]                 s_axis_tready,
  output logic                                    m_axis_tx_tvalid,
  output logic [P_DATA_WIDTH-1:0]                 m_axis_tx_tdata,
  output logic                                    m_axis_tx_tlast,
  output logic [P_DATA_WIDTH/8-1:0]               m_axis_tx_tkeep,
  output logic                                    m_axis_tx_tuser,
  input  logic                                    m_axis_tx_tready,
  output logic                                    o_busy,
  output logic [31:0]                             o_pkt_cnt
);
  import crossbar_pkg::*;

  localparam int P_KEEP_W = P_DATA_WIDTH / 8;
  localparam int P_IDX_W  = (P_CROSSBAR_N > 1) ? $clog2(P_CROSSBAR_N) : 1;

  state_e                  r_state;
  logic [P_CROSSBAR_N-1:0] r_grant;
  logic [P_IDX_W-1:0]      r_ptr;
  logic [31:0]             r_pkt_cnt;
  logic                    r_started;   // a beat of the current packet has moved

  logic [P_CROSSBAR_N-1:0] w_pick;
  logic                    w_pick_valid;
  logic [P_IDX_W-1:0]      w_idx;
  logic [P_IDX_W-1:0]      w_ptr_next;
  logic                    w_req_sel;
  logic                    w_xfer;
  logic                    w_eop;
  logic                    w_abort;

  crossbar_rr_pick #(
    .P_CROSSBAR_N (P_CROSSBAR_N),
    .P_IDX_W      (P_IDX_W)
  ) u_rr_pick (
    .i_req    (i_trans_req),
    .i_ptr    (r_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  assign w_idx      = P_IDX_W'(onehot_to_idx(32'(r_grant)));
  assign w_ptr_next = (w_idx == P_IDX_W'(P_CROSSBAR_N - 1)) ? '0 : (w_idx + P_IDX_W'(1));

  // Grant is zero outside GRANT, so every grant-masked term is inert while idle.
  assign m_axis_tx_tvalid = |(s_axis_tvalid & r_grant);
  assign m_axis_tx_tlast  = |(s_axis_tlast  & r_grant);
  assign m_axis_tx_tuser  = |(s_axis_tuser  & r_grant);
  assign s_axis_tready    = r_grant & {P_CROSSBAR_N{m_axis_tx_tready}};

  assign w_req_sel = |(i_trans_req & r_grant);
  assign w_xfer    = m_axis_tx_tvalid & m_axis_tx_tready;
  assign w_eop     = w_xfer & m_axis_tx_tlast;
  // A beat moving this cycle counts as the packet having started, so a
  // request drop coinciding with the first beat does not abandon it.
  assign w_abort   = (r_state == ST_GRANT) & ~r_started & ~w_req_sel & ~w_xfer;

  assign o_trans_grant = r_grant;
  assign o_busy        = (r_state == ST_GRANT);
  assign o_pkt_cnt     = r_pkt_cnt;

  // One-hot AND-OR mux of the granted line's data and keep onto the output.
  always_comb begin
    m_axis_tx_tdata = '0;
    m_axis_tx_tkeep = '0;
    for (int k = 0; k < P_CROSSBAR_N; k++) begin
      m_axis_tx_tdata = m_axis_tx_tdata |
                        (s_axis_tdata[k*P_DATA_WIDTH +: P_DATA_WIDTH] & {P_DATA_WIDTH{r_grant[k]}});
      m_axis_tx_tkeep = m_axis_tx_tkeep |
                        (s_axis_tkeep[k*P_KEEP_W +: P_KEEP_W] & {P_KEEP_W{r_grant[k]}});
    end
  end

  // Arbitration FSM: pick in IDLE, hold until tlast or an abort before the first beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_pkt_cnt <= 32'd0;
      r_started <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant   <= w_pick;
            r_state   <= ST_GRANT;
            r_started <= 1'b0;
          end else begin
            r_grant <= '0;
          end
        end
        ST_GRANT: begin
          if (w_eop) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_ptr     <= w_ptr_next;
            r_grant   <= '0;
            r_state   <= ST_IDLE;
          end else if (w_abort) begin
            r_ptr   <= w_ptr_next;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_started <= 1'b1;
          end else begin
            r_started <= r_started;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_grant   <= '0;
          r_started <= 1'b0;
        end
      endcase
    end
  end

endmodule
